// File: rtl/jam_pkg.sv
// Shared types and width helpers for the exhaustive job-assignment search engine.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    PIVOT,
    REV,
    DONE
  } state_t;

  localparam int unsigned DEF_N      = 8;
  localparam int unsigned DEF_COST_W = 7;
  localparam int unsigned DEF_CNT_W  = 16;

  // Wide all-ones seed; truncated to the total-cost width at the point of use.
  localparam logic [63:0] MIN_COST_INIT = '1;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned sum_w(input int unsigned n, input int unsigned cost_w);
    return cost_w + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_perm_next.sv
// Combinational next-lexicographic-permutation step: pivot search, swap and suffix reversal.
module jam_perm_next
  import jam_pkg::*;
#(
  parameter  int unsigned N  = DEF_N,
  localparam int unsigned JW = idx_w(N)
) (
  input  logic [N-1:0][JW-1:0] p,
  output logic                 found,
  output logic [JW-1:0]        i,
  output logic [JW-1:0]        j,
  output logic [N-1:0][JW-1:0] p_next
);

  logic [N-1:0][JW-1:0] swapped;

  always_comb begin
    found   = 1'b0;
    i       = '0;
    j       = '0;
    swapped = p;
    p_next  = p;
    for (int unsigned k = 0; k < N - 1; k++) begin
      if (p[JW'(k)] < p[JW'(k + 1)]) begin
        found = 1'b1;
        i     = JW'(k);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (JW'(k) > i && p[JW'(k)] > p[i]) j = JW'(k);
    end
    swapped[i] = p[j];
    swapped[j] = p[i];
    p_next     = swapped;
    // Element k of the suffix after i takes its mirror position N-1-(k-i-1) = N+i-k.
    for (int unsigned k = 0; k < N; k++) begin
      if (JW'(k) > i) p_next[JW'(k)] = swapped[JW'(N + 32'(i) - k)];
    end
  end

endmodule

// File: rtl/jam_perm_search.sv
// Exhaustive N-worker/N-job assignment search over all N! permutations in lexicographic order.
// Optional best-permutation output is enabled with the JAM_BEST_PERM_EN macro.
module jam_perm_search
  import jam_pkg::*;
#(
  parameter  int unsigned N      = DEF_N,
  parameter  int unsigned COST_W = DEF_COST_W,
  parameter  int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned JW     = idx_w(N),
  localparam int unsigned SUM_W  = sum_w(N, COST_W)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Start,
  output logic              Busy,
  output logic              Req,
  output logic [JW-1:0]     W,
  output logic [JW-1:0]     J,
  input  logic              Cost_vld,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
`ifdef JAM_BEST_PERM_EN
  ,
  output logic [N*JW-1:0]   BestPerm
`endif
);

  function automatic logic [N-1:0][JW-1:0] identity();
    logic [N-1:0][JW-1:0] r;
    for (int unsigned k = 0; k < N; k++) r[k] = JW'(k);
    return r;
  endfunction

  localparam logic [N-1:0][JW-1:0] IDENT    = identity();
  localparam logic [JW-1:0]        LAST     = JW'(N - 1);
  localparam logic [SUM_W-1:0]     MIN_INIT = SUM_W'(MIN_COST_INIT);

  state_t               state, state_nx;
  logic [JW-1:0]        k;
  logic [SUM_W-1:0]     sum;
  logic [N-1:0][JW-1:0] p;
  logic                 piv_found;
  logic [JW-1:0]        piv_i, piv_j;
  logic [N-1:0][JW-1:0] p_next;
  logic                 unused_piv_idx;

  jam_perm_next #(.N(N)) u_next (
    .p      (p),
    .found  (piv_found),
    .i      (piv_i),
    .j      (piv_j),
    .p_next (p_next)
  );

  assign unused_piv_idx = ^{piv_i, piv_j};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = FETCH;
      FETCH:   if (Cost_vld && k == LAST) state_nx = EVAL;
      EVAL:    state_nx = PIVOT;
      PIVOT:   state_nx = piv_found ? REV : DONE;
      REV:     state_nx = FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // W/J track k and p directly; both are frozen outside FETCH, so the last request index holds.
  always_comb begin
    Busy  = (state != IDLE);
    Req   = (state == FETCH);
    Valid = (state == DONE);
    W     = k;
    J     = p[k];
  end

`ifdef JAM_BEST_PERM_EN
  logic [N-1:0][JW-1:0] best;
  assign BestPerm = best;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      k          <= '0;
      sum        <= '0;
      p          <= IDENT;
      MinCost    <= MIN_INIT;
      MatchCount <= '0;
`ifdef JAM_BEST_PERM_EN
      best       <= IDENT;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            k          <= '0;
            sum        <= '0;
            p          <= IDENT;
            MinCost    <= MIN_INIT;
            MatchCount <= '0;
`ifdef JAM_BEST_PERM_EN
            best       <= IDENT;
`endif
          end
        end
        FETCH: begin
          if (Cost_vld) begin
            sum <= sum + SUM_W'(Cost);
            if (k != LAST) k <= k + 1'b1;
          end
        end
        EVAL: begin
          if (sum < MinCost) begin
            MinCost    <= sum;
            MatchCount <= CNT_W'(1);
`ifdef JAM_BEST_PERM_EN
            best       <= p;
`endif
          end else if (sum == MinCost && MatchCount != '1) begin
            MatchCount <= MatchCount + 1'b1;
          end
          sum <= '0;
        end
        // p stays put through PIVOT so the successor computed from it is still valid here.
        REV: begin
          p <= p_next;
          k <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_perm_search.sv
// Directed bench for jam_perm_search at N=3, N=4 and N=6 (optional BestPerm via JAM_BEST_PERM_EN).
module tb_jam_perm_search;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // N=3: constant cost 5, zero-wait
  logic       s3 = 1'b0, b3, r3, v3;
  logic [1:0] w3, j3;
  logic       vld3 = 1'b1;
  logic [6:0] c3 = 7'd5;
  logic [8:0] mc3;
  logic [15:0] cnt3;
  // N=4: diagonal-zero or all-zero cost, zero-wait
  logic       s4 = 1'b0, b4, r4, v4;
  logic [1:0] w4, j4;
  logic       vld4 = 1'b1;
  logic       mode4 = 1'b1;
  logic [6:0] c4;
  logic [8:0] mc4;
  logic [15:0] cnt4;
  // N=6: table-driven, optional random wait states
  logic       s6 = 1'b0, b6, r6, v6;
  logic [2:0] w6, j6;
  logic       vld6 = 1'b0;
  logic       rnd6 = 1'b0, sel6 = 1'b0;
  logic [6:0] c6;
  logic [9:0] mc6;
  logic [15:0] cnt6;
  logic [6:0] tba [0:7][0:7];
  logic [6:0] tbb [0:7][0:7];

`ifdef JAM_BEST_PERM_EN
  logic [5:0]  bp3;
  logic [7:0]  bp4;
  logic [17:0] bp6;
`endif

  assign c4 = (mode4 && (w4 != j4)) ? 7'd10 : 7'd0;
  assign c6 = sel6 ? tbb[w6][j6] : tba[w6][j6];

  jam_perm_search #(.N(3)) u3 (
    .CLK(CLK), .RST_n(RST_n), .Start(s3), .Busy(b3), .Req(r3), .W(w3), .J(j3),
    .Cost_vld(vld3), .Cost(c3), .MinCost(mc3), .MatchCount(cnt3), .Valid(v3)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp3)
`endif
  );

  jam_perm_search #(.N(4)) u4 (
    .CLK(CLK), .RST_n(RST_n), .Start(s4), .Busy(b4), .Req(r4), .W(w4), .J(j4),
    .Cost_vld(vld4), .Cost(c4), .MinCost(mc4), .MatchCount(cnt4), .Valid(v4)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp4)
`endif
  );

  jam_perm_search #(.N(6)) u6 (
    .CLK(CLK), .RST_n(RST_n), .Start(s6), .Busy(b6), .Req(r6), .W(w6), .J(j6),
    .Cost_vld(vld6), .Cost(c6), .MinCost(mc6), .MatchCount(cnt6), .Valid(v6)
`ifdef JAM_BEST_PERM_EN
    , .BestPerm(bp6)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic vsel(input int unsigned wh);
    case (wh)
      3:       return v3;
      4:       return v4;
      default: return v6;
    endcase
  endfunction

  function automatic logic bsel(input int unsigned wh);
    case (wh)
      3:       return b3;
      4:       return b4;
      default: return b6;
    endcase
  endfunction

  task automatic set_start(input int unsigned wh, input logic val);
    case (wh)
      3:       s3 = val;
      4:       s4 = val;
      default: s6 = val;
    endcase
  endtask

  // Start, optionally re-pulse Start at cycle `poke`, wait for Valid, then pulse Start in the DONE cycle.
  task automatic run(input int unsigned wh, input int unsigned poke, input int unsigned budget,
                     output int unsigned cyc);
    set_start(wh, 1'b1);
    tick();
    cyc = 1;
    while (!vsel(wh) && cyc < budget) begin
      set_start(wh, cyc == poke);
      tick();
      cyc++;
    end
    chk("valid_seen", 64'(vsel(wh)), 64'd1);
    set_start(wh, 1'b1);
    tick();
    set_start(wh, 1'b0);
    chk("valid_one_cycle", 64'(vsel(wh)), 64'd0);
    chk("done_start_ignored", 64'(bsel(wh)), 64'd0);
  endtask

  // Reference: bitmask DP over assigned-job sets, tracking min total and number of optimal completions.
  task automatic gold(input logic use_b, output int unsigned gmin, output int unsigned gcnt);
    int unsigned dmin [64];
    int unsigned dcnt [64];
    for (int m = 0; m < 64; m++) begin
      dmin[m] = 32'hFFFF_FFFF;
      dcnt[m] = 0;
    end
    dmin[0] = 0;
    dcnt[0] = 1;
    for (int m = 0; m < 64; m++) begin
      if (dcnt[m] != 0 && $countones(m) < 6) begin
        int w;
        w = $countones(m);
        for (int jj = 0; jj < 6; jj++) begin
          if (((m >> jj) & 1) == 0) begin
            int nm;
            int unsigned c;
            nm = m | (1 << jj);
            c = dmin[m] + int'(use_b ? tbb[w][jj] : tba[w][jj]);
            if (c < dmin[nm]) begin
              dmin[nm] = c;
              dcnt[nm] = dcnt[m];
            end else if (c == dmin[nm]) begin
              dcnt[nm] = dcnt[nm] + dcnt[m];
            end
          end
        end
      end
    end
    gmin = dmin[63];
    gcnt = dcnt[63];
  endtask

  // Memory responder for N=6: 0..3 wait states per cost when rnd6 is set; W/J must hold across waits.
  int unsigned wcnt6 = 0;
  logic        prev_req6 = 1'b0, prev_vld6 = 1'b0;
  logic [2:0]  prev_w6 = '0, prev_j6 = '0;
  always @(negedge CLK) begin
    if (rnd6 && r6 && prev_req6 && !prev_vld6) begin
      chk("wait_w_stable", 64'(w6), 64'(prev_w6));
      chk("wait_j_stable", 64'(j6), 64'(prev_j6));
    end
    prev_req6 = r6;
    prev_w6   = w6;
    prev_j6   = j6;
    if (!r6) begin
      vld6 = 1'b0;
    end else if (wcnt6 > 0) begin
      vld6 = 1'b0;
      wcnt6--;
    end else begin
      vld6  = 1'b1;
      wcnt6 = rnd6 ? $urandom_range(0, 3) : 0;
    end
    prev_vld6 = vld6;
  end

  initial begin
    int unsigned cyc, gmin, gcnt;
    for (int w = 0; w < 8; w++) begin
      for (int jj = 0; jj < 8; jj++) begin
        tba[w][jj] = 7'((w * 7 + jj * 3 + w * jj * 5) % 16);
        tbb[w][jj] = 7'((w * 7 + jj * 3 + w * jj * 5) % 16 + 20);
      end
    end

    RST_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_min3",   64'(mc3),  64'h1FF);
    chk("rst_cnt3",   64'(cnt3), 64'd0);
    chk("rst_busy3",  64'(b3),   64'd0);
    chk("rst_req3",   64'(r3),   64'd0);
    chk("rst_valid3", 64'(v3),   64'd0);
    chk("rst_w3",     64'(w3),   64'd0);
    chk("rst_j3",     64'(j3),   64'd0);
    chk("rst_req4",   64'(r4),   64'd0);
    chk("rst_min6",   64'(mc6),  64'h3FF);
    chk("rst_cnt6",   64'(cnt6), 64'd0);
`ifdef JAM_BEST_PERM_EN
    chk("rst_bp6",    64'(bp6),  64'h2C688);
`endif
    RST_n = 1'b1;
    tick();

    // N=3 constant cost, mid-search Start at cycle 10 must be ignored
    run(3, 10, 200, cyc);
    chk("n3_cycles", 64'(cyc),  64'd36);
    chk("n3_min",    64'(mc3),  64'd15);
    chk("n3_cnt",    64'(cnt3), 64'd6);
`ifdef JAM_BEST_PERM_EN
    chk("n3_bp",     64'(bp3),  64'h24);
`endif
    tick();
    chk("n3_min_hold", 64'(mc3),  64'd15);
    chk("n3_cnt_hold", 64'(cnt3), 64'd6);

    // N=4 diagonal-zero then all-zero back to back
    mode4 = 1'b1;
    run(4, 0, 400, cyc);
    chk("n4d_cycles", 64'(cyc),  64'd168);
    chk("n4d_min",    64'(mc4),  64'd0);
    chk("n4d_cnt",    64'(cnt4), 64'd1);
`ifdef JAM_BEST_PERM_EN
    chk("n4d_bp",     64'(bp4),  64'hE4);
`endif
    mode4 = 1'b0;
    run(4, 0, 400, cyc);
    chk("n4z_min",    64'(mc4),  64'd0);
    chk("n4z_cnt",    64'(cnt4), 64'd24);
`ifdef JAM_BEST_PERM_EN
    chk("n4z_bp",     64'(bp4),  64'hE4);
`endif

    // N=6 table A zero-wait, table A random waits, then table B random waits
    rnd6 = 1'b0;
    sel6 = 1'b0;
    gold(1'b0, gmin, gcnt);
    run(6, 0, 8000, cyc);
    chk("n6a_cycles", 64'(cyc),  64'd6480);
    chk("n6a_min",    64'(mc6),  64'(gmin));
    chk("n6a_cnt",    64'(cnt6), 64'(gcnt));
    rnd6 = 1'b1;
    run(6, 0, 40000, cyc);
    chk("n6a_wait_min", 64'(mc6),  64'(gmin));
    chk("n6a_wait_cnt", 64'(cnt6), 64'(gcnt));
    sel6 = 1'b1;
    gold(1'b1, gmin, gcnt);
    run(6, 0, 40000, cyc);
    chk("n6b_min",    64'(mc6),  64'(gmin));
    chk("n6b_cnt",    64'(cnt6), 64'(gcnt));
    rnd6 = 1'b0;

    // Asynchronous reset in the middle of a FETCH phase
    set_start(3, 1'b1);
    tick();
    set_start(3, 1'b0);
    cyc = 1;
    while (!(cyc >= 8 && r3) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("pre_rst_req", 64'(r3),  64'd1);
    chk("pre_rst_min", 64'(mc3), 64'd15);
    #2;
    RST_n = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(b3),   64'd0);
    chk("mid_rst_req",   64'(r3),   64'd0);
    chk("mid_rst_min",   64'(mc3),  64'h1FF);
    chk("mid_rst_cnt",   64'(cnt3), 64'd0);
    chk("mid_rst_w",     64'(w3),   64'd0);
    chk("mid_rst_j",     64'(j3),   64'd0);
    chk("mid_rst_valid", 64'(v3),   64'd0);
    tick();
    RST_n = 1'b1;
    tick();
    run(3, 0, 200, cyc);
    chk("n3r_cycles", 64'(cyc),  64'd36);
    chk("n3r_min",    64'(mc3),  64'd15);
    chk("n3r_cnt",    64'(cnt3), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
